instr_encoder_loader: RTL and testbench

//  Writer side of the instruction-word interface that the control unit decodes.

---
 rtl/instr_encoder_loader_pkg.sv | 26 ++
 rtl/instr_encoder_loader_if.sv | 34 +++
 rtl/instr_encoder_loader_word_pack.sv | 58 +++++
 rtl/instr_encoder_loader.sv | 123 ++++++++++++
 tb/tb_instr_encoder_loader.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_encoder_loader_pkg.sv
// Constants shared by the instruction loader and the control unit that decodes its output.
// The package holds the opcodes, instruction kinds and loader state encodings.
package instr_encoder_loader_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FUNCT_JR = 6'd8;

    typedef enum logic [1:0] {
        KIND_R    = 2'd0,
        KIND_I    = 2'd1,
        KIND_J    = 2'd2,
        KIND_RSVD = 2'd3
    } instr_kind_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle stream in, instruction-memory write port out.
// slave is the loader's view; master is the producer/memory side.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              inValid;
    logic              inReady;
    logic [1:0]        inKind;
    logic [5:0]        inOpcode;
    logic [4:0]        inRs;
    logic [4:0]        inRt;
    logic [4:0]        inRd;
    logic [4:0]        inShamt;
    logic [5:0]        inFunct;
    logic [15:0]       inImm;
    logic [25:0]       inTarget;
    logic              inLast;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic              memReady;

    modport slave (
        input  inValid, inKind, inOpcode, inRs, inRt, inRd, inShamt,
               inFunct, inImm, inTarget, inLast, memReady,
        output inReady, memWe, memAddr, memWdata
    );

    modport master (
        output inValid, inKind, inOpcode, inRs, inRt, inRd, inShamt,
               inFunct, inImm, inTarget, inLast, memReady,
        input  inReady, memWe, memAddr, memWdata
    );
endinterface

// File: rtl/instr_encoder_loader_word_pack.sv
// Combinational packer: instruction fields -> 32-bit MIPS word plus a legality flag.
// Only the opcode/kind pairs the control unit decodes are reported legal.
module instr_word_pack
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]  kind,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);
    localparam int N_IOPS = 5;
    localparam int N_JOPS = 2;
    localparam logic [5:0] I_OPS [N_IOPS] = '{OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    localparam logic [5:0] J_OPS [N_JOPS] = '{OP_J, OP_JAL};

    logic [N_IOPS-1:0] iHit;
    logic [N_JOPS-1:0] jHit;

    generate
        for (genvar gi = 0; gi < N_IOPS; gi++) begin : g_iop
            assign iHit[gi] = (opcode == I_OPS[gi]);
        end
        for (genvar gi = 0; gi < N_JOPS; gi++) begin : g_jop
            assign jHit[gi] = (opcode == J_OPS[gi]);
        end
    endgenerate

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (kind)
            KIND_R: begin
                // R-type words always carry opcode 0 regardless of the input opcode field
                word  = {OP_RTYPE, rs, rt, rd, shamt, funct};
                legal = (opcode == OP_RTYPE);
            end
            KIND_I: begin
                word  = {opcode, rs, rt, imm};
                legal = |iHit;
            end
            KIND_J: begin
                word  = {opcode, target};
                legal = |jHit;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Streams packed instruction words into instruction memory from address 0.
// One bundle is held per write; illegal bundles are counted and dropped.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_W:0]       wordCount,
    output logic [7:0]            errCount,
    output logic                  done,
    output logic                  full
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic [1:0]        stateReg;
    logic [ADDR_W-1:0] memAddrReg;
    logic [31:0]       wordReg;
    logic              lastReg;
    logic [ADDR_W:0]   wordCountReg;
    logic [7:0]        errCountReg;
    logic              doneReg;
    logic              fullReg;

    logic [31:0]       packedWord;
    logic              packedLegal;
    logic              accept;

    instr_word_pack u_pack (
        .kind   (bus.inKind),
        .opcode (bus.inOpcode),
        .rs     (bus.inRs),
        .rt     (bus.inRt),
        .rd     (bus.inRd),
        .shamt  (bus.inShamt),
        .funct  (bus.inFunct),
        .imm    (bus.inImm),
        .target (bus.inTarget),
        .word   (packedWord),
        .legal  (packedLegal)
    );

    // A start pulse wins over a same-cycle bundle, so refuse it rather than lose it
    assign bus.inReady  = (stateReg == ST_IDLE) && !start;
    assign accept       = bus.inValid && bus.inReady;
    assign bus.memWe    = (stateReg == ST_WRITE);
    assign bus.memAddr  = memAddrReg;
    assign bus.memWdata = wordReg;

    assign wordCount = wordCountReg;
    assign errCount  = errCountReg;
    assign done      = doneReg;
    assign full      = fullReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= ST_IDLE;
            memAddrReg   <= '0;
            wordReg      <= '0;
            lastReg      <= 1'b0;
            wordCountReg <= '0;
            errCountReg  <= '0;
            doneReg      <= 1'b0;
            fullReg      <= 1'b0;
        end else if (start) begin
            stateReg     <= ST_IDLE;
            memAddrReg   <= '0;
            lastReg      <= 1'b0;
            wordCountReg <= '0;
            errCountReg  <= '0;
            doneReg      <= 1'b0;
            fullReg      <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE: begin
                    if (accept) begin
                        if (packedLegal) begin
                            wordReg  <= packedWord;
                            lastReg  <= bus.inLast;
                            stateReg <= ST_WRITE;
                        end else begin
                            if (errCountReg != 8'hFF) begin
                                errCountReg <= errCountReg + 8'd1;
                            end
                            if (bus.inLast) begin
                                doneReg  <= 1'b1;
                                stateReg <= ST_DONE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (bus.memReady) begin
                        wordCountReg <= wordCountReg + (ADDR_W+1)'(1);
                        // The top address is terminal: the pointer parks there instead of wrapping
                        if (memAddrReg == ADDR_MAX) begin
                            fullReg  <= 1'b1;
                            doneReg  <= 1'b1;
                            stateReg <= ST_DONE;
                        end else begin
                            memAddrReg <= memAddrReg + ADDR_W'(1);
                            if (lastReg) begin
                                doneReg  <= 1'b1;
                                stateReg <= ST_DONE;
                            end else begin
                                stateReg <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    stateReg <= ST_DONE;
                end
                default: begin
                    stateReg <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: the driver pushes expected writes, negedge monitors pop and compare.
// A second 4-word instance covers the memory-full path.
module tb_instr_encoder_loader;
    import instr_encoder_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       bStart, sStart;
    logic [8:0] bWordCount;
    logic [7:0] bErrCount;
    logic       bDone, bFull;
    logic [2:0] sWordCount;
    logic [7:0] sErrCount;
    logic       sDone, sFull;

    instr_encoder_loader_if #(.ADDR_W(8)) bigIf ();
    instr_encoder_loader_if #(.ADDR_W(2)) smlIf ();

    instr_encoder_loader #(.ADDR_W(8)) dutBig (
        .clk(clk), .reset(reset), .start(bStart), .bus(bigIf.slave),
        .wordCount(bWordCount), .errCount(bErrCount), .done(bDone), .full(bFull)
    );
    instr_encoder_loader #(.ADDR_W(2)) dutSml (
        .clk(clk), .reset(reset), .start(sStart), .bus(smlIf.slave),
        .wordCount(sWordCount), .errCount(sErrCount), .done(sDone), .full(sFull)
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the spec's field layout and legal opcode table, in plain arithmetic
    function automatic bit refLegal(input int kind, input int op);
        case (kind)
            0: return op == 0;
            1: return op == 4 || op == 5 || op == 8 || op == 35 || op == 43;
            2: return op == 2 || op == 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] refWord(input int kind, input int op, input int rs, input int rt,
                                            input int rd, input int sh, input int fn, input int imm,
                                            input int tgt);
        longint w;
        case (kind)
            0: w = rs * 2**21 + rt * 2**16 + rd * 2**11 + sh * 2**6 + fn;
            1: w = longint'(op) * 2**26 + rs * 2**21 + rt * 2**16 + imm;
            default: w = longint'(op) * 2**26 + tgt;
        endcase
        return w[31:0];
    endfunction

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int expAddr = 0, expWords = 0, expErr = 0;
    int weHigh = 0;
    bit rndReady = 0, forceReady = 1, mrRand = 1;

    assign bigIf.memReady = rndReady ? mrRand : forceReady;
    assign smlIf.memReady = 1'b1;

    always @(posedge clk) begin
        #1 mrRand = ($urandom_range(0, 3) != 0);
    end

    // Big-instance monitor: every cycle with memWe high must show the scoreboard head
    always @(negedge clk) begin
        if (!reset && bigIf.memWe) begin
            weHigh++;
            if (sb.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         bigIf.memAddr, bigIf.memWdata);
            end else begin
                check("wr_addr", 32'(bigIf.memAddr), sb[0].addr);
                check("wr_data", bigIf.memWdata, sb[0].data);
                if (bigIf.memReady) begin
                    $display("write addr=%0d data=0x%08h", bigIf.memAddr, bigIf.memWdata);
                    void'(sb.pop_front());
                    expWords++;
                end
            end
        end
    end

    int sAccepts = 0, sWrites = 0, sExpAddr = 0;
    always @(negedge clk) begin
        if (!reset && smlIf.inValid && smlIf.inReady) sAccepts++;
        if (!reset && smlIf.memWe && smlIf.memReady) begin
            $display("small write addr=%0d data=0x%08h", smlIf.memAddr, smlIf.memWdata);
            check("small_wr_addr", 32'(smlIf.memAddr), sExpAddr);
            sExpAddr++;
            sWrites++;
        end
    end

    task automatic sendBig(input int kind, input int op, input int rs, input int rt, input int rd,
                           input int sh, input int fn, input int imm, input int tgt, input bit last);
        bit got = 0;
        bigIf.inKind   = kind[1:0];
        bigIf.inOpcode = op[5:0];
        bigIf.inRs     = rs[4:0];
        bigIf.inRt     = rt[4:0];
        bigIf.inRd     = rd[4:0];
        bigIf.inShamt  = sh[4:0];
        bigIf.inFunct  = fn[5:0];
        bigIf.inImm    = imm[15:0];
        bigIf.inTarget = tgt[25:0];
        bigIf.inLast   = last;
        bigIf.inValid  = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (bigIf.inReady) got = 1;
        end
        if (!got) begin
            nChecks++;
            nFail++;
            $display("FAIL accept_timeout: got inReady=0 for 200 cycles, expected 1");
        end else if (refLegal(kind, op)) begin
            sb.push_back('{expAddr, refWord(kind, op, rs, rt, rd, sh, fn, imm, tgt)});
            expAddr++;
        end else if (expErr < 255) begin
            expErr++;
        end
        @(posedge clk);
        #1 bigIf.inValid = 1'b0;
    endtask

    task automatic waitQuiet();
        bit ok = 0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bigIf.memWe) ok = 1;
        end
        if (!ok) begin
            nChecks++;
            nFail++;
            $display("FAIL drain_timeout: got %0d pending writes, expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        bStart = 1'b1;
        @(posedge clk);
        #1 bStart = 1'b0;
        sb.delete();
        expAddr  = 0;
        expWords = 0;
        expErr   = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1);
    end

    int weBefore, addrBefore;
    int iOps[5] = '{4, 5, 8, 35, 43};

    initial begin
        reset = 1'b1; bStart = 1'b0; sStart = 1'b0;
        bigIf.inValid = 1'b0; bigIf.inKind = '0; bigIf.inOpcode = '0; bigIf.inRs = '0;
        bigIf.inRt = '0; bigIf.inRd = '0; bigIf.inShamt = '0; bigIf.inFunct = '0;
        bigIf.inImm = '0; bigIf.inTarget = '0; bigIf.inLast = 1'b0;
        smlIf.inValid = 1'b0; smlIf.inKind = 2'd0; smlIf.inOpcode = 6'd0; smlIf.inRs = 5'd1;
        smlIf.inRt = 5'd2; smlIf.inRd = 5'd3; smlIf.inShamt = 5'd0; smlIf.inFunct = 6'h20;
        smlIf.inImm = '0; smlIf.inTarget = '0; smlIf.inLast = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_memWe", 32'(bigIf.memWe), 0);
        check("rst_memAddr", 32'(bigIf.memAddr), 0);
        check("rst_memWdata", bigIf.memWdata, 0);
        check("rst_wordCount", 32'(bWordCount), 0);
        check("rst_errCount", 32'(bErrCount), 0);
        check("rst_done_full", {30'd0, bDone, bFull}, 0);
        reset = 1'b0;
        check("idle_inReady", 32'(bigIf.inReady), 1);

        // add $3,$1,$2
        sendBig(0, 0, 1, 2, 3, 0, 'h20, 0, 0, 0);
        check("add_word_model", sb[0].data, 32'h0022_1820);
        waitQuiet();
        check("add_wordCount", 32'(bWordCount), 1);

        // lw then j (last) from a fresh start
        pulseStart();
        check("start_memAddr", 32'(bigIf.memAddr), 0);
        sendBig(1, 35, 16, 8, 0, 0, 0, 4, 0, 0);
        sendBig(2, 2, 0, 0, 0, 0, 0, 0, 'h0100000, 1);
        waitQuiet();
        check("prog_done", 32'(bDone), 1);
        check("prog_inReady", 32'(bigIf.inReady), 0);
        check("prog_wordCount", 32'(bWordCount), 2);
        check("prog_full", 32'(bFull), 0);
        pulseStart();
        check("rearm_done", 32'(bDone), 0);

        // stalled write: memReady low for three cycles
        forceReady = 0;
        weBefore = weHigh;
        addrBefore = 32'(bigIf.memAddr);
        sendBig(1, 43, 29, 31, 0, 0, 0, 'hFFFC, 0, 0);
        repeat (3) @(posedge clk);
        #1 forceReady = 1;
        waitQuiet();
        check("stall_we_cycles", weHigh - weBefore, 4);
        check("stall_addr_inc", 32'(bigIf.memAddr), addrBefore + 1);

        // illegal bundles: R with opcode 4, then reserved kind
        weBefore = weHigh;
        addrBefore = 32'(bigIf.memAddr);
        sendBig(0, 4, 1, 2, 3, 0, 'h20, 0, 0, 0);
        sendBig(3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_errCount", 32'(bErrCount), 2);
        check("illegal_no_write", weHigh - weBefore, 0);
        check("illegal_addr", 32'(bigIf.memAddr), addrBefore);

        // reset during a stalled write
        forceReady = 0;
        sendBig(2, 3, 0, 0, 0, 0, 0, 'h3FFFFFF, 0, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        expAddr = 0; expWords = 0; expErr = 0;
        forceReady = 1;
        check("rst_wr_memWe", 32'(bigIf.memWe), 0);
        check("rst_wr_memAddr", 32'(bigIf.memAddr), 0);
        check("rst_wr_wordCount", 32'(bWordCount), 0);
        check("rst_wr_inReady", 32'(bigIf.inReady), 1);

        // randomized mix with random memory back-pressure
        rndReady = 1;
        for (int n = 0; n < 120; n++) begin
            int k, op;
            k = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) begin
                case (k)
                    0: op = 0;
                    1: op = iOps[$urandom_range(0, 4)];
                    default: op = $urandom_range(2, 3);
                endcase
            end else begin
                op = $urandom_range(0, 63);
            end
            sendBig(k, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 65535),
                    $urandom_range(0, 32'h3FFFFFF), 0);
        end
        waitQuiet();
        check("rnd_wordCount", 32'(bWordCount), expWords);
        check("rnd_errCount", 32'(bErrCount), expErr);
        check("rnd_memAddr", 32'(bigIf.memAddr), expAddr);
        sendBig(1, 8, 4, 5, 0, 0, 0, 'h1234, 0, 1);
        waitQuiet();
        check("rnd_done", 32'(bDone), 1);
        rndReady = 0;

        // four-word memory: fill it, then re-arm
        smlIf.inValid = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("full_accepts", sAccepts, 4);
        check("full_writes", sWrites, 4);
        check("full_flags", {30'd0, sDone, sFull}, 3);
        check("full_wordCount", 32'(sWordCount), 4);
        check("full_memAddr", 32'(smlIf.memAddr), 3);
        check("full_inReady", 32'(smlIf.inReady), 0);
        sStart = 1'b1;
        @(posedge clk);
        #1 sStart = 1'b0;
        sExpAddr = 0;
        check("rearm_memAddr", 32'(smlIf.memAddr), 0);
        check("rearm_flags", {30'd0, sDone, sFull}, 0);
        check("rearm_wordCount", 32'(sWordCount), 0);
        repeat (3) @(posedge clk);
        #1 smlIf.inValid = 1'b0;
        check("rearm_writes", sWrites, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
